// File: rtl/gauss_line_buffer.sv
// rtl/gauss_line_buffer.sv - three-row sliding line buffer feeding the 3x3 Gaussian filter
// Two register-based line memories so reset can clear all history in one edge.
module gauss_line_buffer #(
  parameter int W = 640
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pixel_in,
  input  logic       valid_in,
  output logic [7:0] top,
  output logic [7:0] mid,
  output logic [7:0] bot
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  logic [7:0]    l1_q [W];
  logic [7:0]    l1_d [W];
  logic [7:0]    l2_q [W];
  logic [7:0]    l2_d [W];
  logic [CW-1:0] col_q;
  logic [CW-1:0] col_d;

  // Row shift happens per column: the previous row's entry ages into L2 as
  // the current pixel overwrites it in L1.
  always_comb begin
    l1_d  = l1_q;
    l2_d  = l2_q;
    col_d = col_q;
    if (valid_in) begin
      l2_d[col_q] = l1_q[col_q];
      l1_d[col_q] = pixel_in;
      col_d       = (col_q == COL_LAST) ? '0 : col_q + COL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < W; i++) begin
        l1_q[i] <= '0;
        l2_q[i] <= '0;
      end
      col_q <= '0;
    end else begin
      l1_q  <= l1_d;
      l2_q  <= l2_d;
      col_q <= col_d;
    end
  end

  assign bot = pixel_in;
  assign mid = l1_q[col_q];
  assign top = l2_q[col_q];

endmodule

// File: tb/tb_gauss_line_buffer.sv
// tb/tb_gauss_line_buffer.sv - directed bench for gauss_line_buffer with W = 9
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_gauss_line_buffer;

  localparam int W = 9;

  logic       clk;
  logic       rst;
  logic [7:0] pixel_in;
  logic       valid_in;
  logic [7:0] top;
  logic [7:0] mid;
  logic [7:0] bot;

  int n_assert;
  int n_fail;

  gauss_line_buffer #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .pixel_in (pixel_in),
    .valid_in (valid_in),
    .top      (top),
    .mid      (mid),
    .bot      (bot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [7:0] pix, input logic vld);
    @(negedge clk);
    pixel_in = pix;
    valid_in = vld;
    #1;
  endtask

  task automatic check_col(input string tag, input logic [7:0] eb, input logic [7:0] em,
                           input logic [7:0] et);
    check({tag, " bot"}, bot, eb);
    check({tag, " mid"}, mid, em);
    check({tag, " top"}, top, et);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    valid_in = 1'b0;
    pixel_in = 8'h5a;
    repeat (2) @(posedge clk);
    #1;
    check_col("reset", 8'h5a, 8'h00, 8'h00);

    // Six rows of r*16+c with a three-cycle stall before row 3, column 4.
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == 3 && c == 4) begin
          for (int s = 0; s < 3; s++) begin
            present(8'hee, 1'b0);
            check_col($sformatf("stall%0d", s), 8'hee, 8'h24, 8'h14);
          end
        end
        present(8'(r * 16 + c), 1'b1);
        check_col($sformatf("r%0d c%0d", r, c), 8'(r * 16 + c),
                  (r >= 1) ? 8'((r - 1) * 16 + c) : 8'h00,
                  (r >= 2) ? 8'((r - 2) * 16 + c) : 8'h00);
      end
    end

    // Partial row 6, then reset with valid_in high to show reset priority.
    for (int c = 0; c < 6; c++) begin
      present(8'(96 + c), 1'b1);
      check_col($sformatf("r6 c%0d", c), 8'(96 + c), 8'(80 + c), 8'(64 + c));
    end
    @(negedge clk);
    rst      = 1'b1;
    valid_in = 1'b1;
    pixel_in = 8'hff;
    #1;
    check_col("pre-reset c6", 8'hff, 8'h56, 8'h46);
    @(negedge clk);
    rst = 1'b0;
    valid_in = 1'b0;
    pixel_in = 8'h33;
    #1;
    check_col("post-reset", 8'h33, 8'h00, 8'h00);

    // New pattern 0x80 + r*16 + c restarting at row 0, column 0.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        present(8'(128 + r * 16 + c), 1'b1);
        check_col($sformatf("n r%0d c%0d", r, c), 8'(128 + r * 16 + c),
                  (r >= 1) ? 8'(128 + (r - 1) * 16 + c) : 8'h00,
                  (r >= 2) ? 8'(128 + (r - 2) * 16 + c) : 8'h00);
      end
    end

    // Stall right at the last column, then check the wrap to the next row.
    present(8'h7e, 1'b0);
    check_col("stall wrap", 8'h7e, 8'ha0, 8'h90);
    present(8'hb0, 1'b1);
    check_col("wrap c0", 8'hb0, 8'ha0, 8'h90);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
